// File: rtl/data_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : data_mem_ctrl
// Brief    : Two-port round-robin sequencer in front of a word-addressed
//            data_mem; converts RV32 byte/half/word accesses, RMW for sub-word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl #(
   parameter int MEM_DEPTH  = 256,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [1:0]            a_size,
   input  logic                  a_unsigned,
   input  logic [31:0]           a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_done,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [1:0]            b_size,
   input  logic                  b_unsigned,
   input  logic [31:0]           b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_done,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [29:0] c_depth = 30'(MEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_MERGE  = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_we;
   logic                  r_uns;
   logic [1:0]            r_size;
   logic [31:0]           r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;
   logic                  r_owner;   // 0 = A, 1 = B
   logic                  r_last;    // last granted port, 1 = B

   logic                  w_sel_b;
   logic                  w_we;
   logic                  w_uns;
   logic [1:0]            w_size;
   logic [31:0]           w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_load;
   logic [DATA_WIDTH-1:0] w_merged;

   // Round robin: on a tie the port that did not win last time goes first.
   assign a_gnt = rst_n && (r_state == S_IDLE) && a_req && (!b_req || r_last);
   assign b_gnt = rst_n && (r_state == S_IDLE) && b_req && (!a_req || !r_last);

   assign w_sel_b = b_gnt;
   assign w_we    = w_sel_b ? b_we       : a_we;
   assign w_uns   = w_sel_b ? b_unsigned : a_unsigned;
   assign w_size  = w_sel_b ? b_size     : a_size;
   assign w_addr  = w_sel_b ? b_addr     : a_addr;
   assign w_wdata = w_sel_b ? b_wdata    : a_wdata;

   assign w_err = (w_size == 2'b11)
               || ((w_size == 2'b01) && w_addr[0])
               || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
               || (w_addr[31:2] >= c_depth);

   // Addressed lane lands at bit 0; legal halves only shift by 0 or 16.
   assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      case (r_size)
         2'b00:   w_load = {{24{~r_uns & w_shifted[7]}},  w_shifted[7:0]};
         2'b01:   w_load = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
         default: w_load = mem_rdata;
      endcase
   end

   always_comb begin
      w_merged = mem_rdata;
      if (r_size == 2'b00) begin
         case (r_addr[1:0])
            2'd0: w_merged[7:0]   = r_wdata[7:0];
            2'd1: w_merged[15:8]  = r_wdata[7:0];
            2'd2: w_merged[23:16] = r_wdata[7:0];
            2'd3: w_merged[31:24] = r_wdata[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merged[31:16] = r_wdata[15:0];
      end else begin
         w_merged[15:0] = r_wdata[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (a_gnt || b_gnt) begin
                  r_we    <= w_we;
                  r_uns   <= w_uns;
                  r_size  <= w_size;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_rdata <= '0;
                  r_err   <= w_err;
                  r_owner <= w_sel_b;
                  r_last  <= w_sel_b;
                  r_state <= w_err ? S_RESP : S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!r_we) begin
                  r_rdata <= w_load;
                  r_state <= S_RESP;
               end else if (r_size == 2'b10) begin
                  r_state <= S_RESP;
               end else begin
                  // Merged word reuses the store-data register for the MERGE write.
                  r_wdata <= w_merged;
                  r_state <= S_MERGE;
               end
            end
            S_MERGE: r_state <= S_RESP;
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      a_done    = (r_state == S_RESP) && !r_owner;
      b_done    = (r_state == S_RESP) &&  r_owner;
      rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
      rsp_err   = (r_state == S_RESP) && r_err;
      mem_we    = ((r_state == S_ACCESS) && r_we && (r_size == 2'b10))
               || (r_state == S_MERGE);
      mem_addr  = ((r_state == S_ACCESS) || (r_state == S_MERGE))
               ? {2'b00, r_addr[31:2]} : '0;
      mem_wdata = mem_we ? r_wdata : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_data_mem_ctrl
// Brief    : Self-checking bench for data_mem_ctrl with a behavioural memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, a_unsigned = 1'b0;
   logic [1:0]  a_size = 2'b00;
   logic [31:0] a_addr = '0, a_wdata = '0;
   logic        b_req = 1'b0, b_we = 1'b0, b_unsigned = 1'b0;
   logic [1:0]  b_size = 2'b00;
   logic [31:0] b_addr = '0, b_wdata = '0;
   logic        a_gnt, a_done, b_gnt, b_done, rsp_err, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [0:255] = '{default: 32'h0};
   logic [31:0] ref_mem [0:255] = '{default: 32'h0};
   int          we_cnt = 0;
   logic [31:0] we_addr = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   data_mem_ctrl #(.MEM_DEPTH(256), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_unsigned(a_unsigned),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_done(a_done),
      .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_unsigned(b_unsigned),
      .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_done(b_done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural data_mem: combinational read, synchronous write.
   assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;
   always @(posedge clk) if (mem_we === 1'b1 && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;

   always @(negedge clk) if (mem_we === 1'b1) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
   end

   // Reference: expected result from RV32 access rules on a plain word array.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] exp_rdata, output logic exp_err, output int exp_lat);
      logic [31:0] mask, word, v, top;
      int shift, widx;
      exp_rdata = 32'h0;
      exp_err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)
             || ((addr >> 2) >= 32'd256);
      if (exp_err) begin
         exp_lat = 1;
         return;
      end
      widx  = int'(addr >> 2);
      mask  = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      shift = 8 * int'(addr % 4);
      word  = ref_mem[widx];
      if (!we) begin
         v   = (word >> shift) & mask;
         top = (mask >> 1) + 1;
         if (!uns && size != 2 && (v & top) != 0) v = v | ~mask;
         exp_rdata = v;
         exp_lat   = 2;
      end else begin
         ref_mem[widx] = (word & ~(mask << shift)) | ((wdata & mask) << shift);
         exp_lat = (size == 2) ? 2 : 3;
      end
   endtask

   // Issues one request, scrambles the port after acceptance, and measures the response.
   task automatic op(input logic port, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output int wecnt, output logic wrong);
      int start_we;
      logic got;
      rdata = 32'hX; err = 1'bX; wrong = 1'b0; lat = 99; wecnt = 0;
      @(negedge clk);
      if (!port) begin
         a_we = we; a_size = size; a_unsigned = uns; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
      end else begin
         b_we = we; b_size = size; b_unsigned = uns; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
      end
      #1;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if ((port ? b_gnt : a_gnt) === 1'b1) begin got = 1'b1; break; end
         @(negedge clk); #1;
      end
      start_we = we_cnt;
      if (got) @(posedge clk);
      #1;
      if (!port) begin
         a_req = 1'b0; a_addr = $urandom; a_wdata = $urandom; a_size = 2'($urandom); a_we = 1'($urandom);
      end else begin
         b_req = 1'b0; b_addr = $urandom; b_wdata = $urandom; b_size = 2'($urandom); b_we = 1'($urandom);
      end
      if (!got) return;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if ((port ? a_done : b_done) !== 1'b0) wrong = 1'b1;
         if ((port ? b_done : a_done) === 1'b1) begin
            rdata = rsp_rdata; err = rsp_err; lat = k;
            break;
         end
      end
      wecnt = we_cnt - start_we;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; a_req = 1'b1; b_req = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if ({a_gnt, b_gnt, a_done, b_done, rsp_err, mem_we} !== 6'b0 || rsp_rdata !== 32'h0
          || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b%b done=%b%b err=%b we=%b rdata=%h addr=%h wdata=%h, required all 0",
                  a_gnt, b_gnt, a_done, b_done, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
      end
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_word_rw;
      logic [31:0] rd, erd; logic er, eer, wr; int lat, elat, wc;
      model(1, 2'b10, 0, 32'hA8, 32'hDEADBEEF, erd, eer, elat);
      op(0, 1, 2'b10, 0, 32'hA8, 32'hDEADBEEF, rd, er, lat, wc, wr);
      n_checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
         n_fail++; $display("FAIL sw_resp: lat=%0d err=%b rdata=%h, required lat=2 err=0 rdata=0", lat, er, rd);
      end
      n_checks++;
      if (wc !== 1 || we_addr !== 32'd42) begin
         n_fail++; $display("FAIL sw_mem_we: cycles=%0d addr=%0d, required 1 cycle at 42", wc, we_addr);
      end
      model(0, 2'b10, 0, 32'hA8, 32'h0, erd, eer, elat);
      op(0, 0, 2'b10, 0, 32'hA8, 32'h0, rd, er, lat, wc, wr);
      n_checks++;
      if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || wc !== 0 || wr) begin
         n_fail++; $display("FAIL lw_a8: lat=%0d rdata=%h err=%b we=%0d wrong=%b, required 2/deadbeef/0/0/0", lat, rd, er, wc, wr);
      end
   endtask

   task automatic test_subword;
      logic [31:0] rd, erd; logic er, eer, wr; int lat, elat, wc;
      logic [31:0] exp_rd [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0};
      logic [1:0]  szs    [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        unss   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] adrs   [4] = '{32'hAB, 32'hAB, 32'hAA, 32'hAA};
      model(1, 2'b00, 0, 32'hA9, 32'h55, erd, eer, elat);
      op(0, 1, 2'b00, 0, 32'hA9, 32'h55, rd, er, lat, wc, wr);
      n_checks++;
      if (lat !== 3 || wc !== 1 || mem[42] !== 32'hDEAD55EF) begin
         n_fail++; $display("FAIL sb_a9: lat=%0d we=%0d word=%h, required 3/1/dead55ef", lat, wc, mem[42]);
      end
      for (int i = 0; i < 4; i++) begin
         logic w; w = (i == 3);
         model(w, szs[i], unss[i], adrs[i], 32'h1234, erd, eer, elat);
         op(0, w, szs[i], unss[i], adrs[i], 32'h1234, rd, er, lat, wc, wr);
         n_checks++;
         if (rd !== exp_rd[i] || er !== 1'b0 || lat !== (w ? 3 : 2)) begin
            n_fail++; $display("FAIL subword_%0d: rdata=%h err=%b lat=%0d, required %h/0/%0d", i, rd, er, lat, exp_rd[i], w ? 3 : 2);
         end
      end
      n_checks++;
      if (mem[42] !== 32'h123455EF) begin
         n_fail++; $display("FAIL sh_aa_word: word=%h, required 123455ef", mem[42]);
      end
   endtask

   task automatic test_errors;
      logic [31:0] rd, erd; logic er, eer, wr; int lat, elat, wc;
      logic        wes [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0]  szs [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
      logic [31:0] ads [4] = '{32'h102, 32'h101, 32'h10, 32'h400};
      for (int i = 0; i < 4; i++) begin
         model(wes[i], szs[i], 0, ads[i], 32'hCAFEF00D, erd, eer, elat);
         op(0, wes[i], szs[i], 0, ads[i], 32'hCAFEF00D, rd, er, lat, wc, wr);
         n_checks++;
         if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
            n_fail++; $display("FAIL err_%0d: lat=%0d err=%b rdata=%h we=%0d, required 1/1/0/0", i, lat, er, rd, wc);
         end
      end
   endtask

   task automatic test_unwritten;
      logic [31:0] rd, erd; logic er, eer, wr; int lat, elat, wc;
      model(0, 2'b10, 0, 32'hDC, 32'h0, erd, eer, elat);
      op(1, 0, 2'b10, 0, 32'hDC, 32'h0, rd, er, lat, wc, wr);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 2 || wr) begin
         n_fail++; $display("FAIL lw_unwritten: rdata=%h err=%b lat=%0d wrong=%b, required 0/0/2/0", rd, er, lat, wr);
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] gb = 4'bxxxx, db = 4'bxxxx;
      int ng = 0, nd = 0, both = 0, lat = 99;
      logic lone_gnt;
      logic [31:0] rd = 32'hX;
      rst_n = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_size = 2'b10; a_addr = 32'hA8;
      b_req = 1'b1; b_we = 1'b0; b_size = 2'b10; b_addr = 32'hDC;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (a_gnt === 1'b1 && b_gnt === 1'b1) both++;
         if (a_gnt === 1'b1 && ng < 4) begin gb[3 - ng] = 1'b0; ng++; end
         else if (b_gnt === 1'b1 && ng < 4) begin gb[3 - ng] = 1'b1; ng++; end
         if (a_done === 1'b1 && nd < 4) begin db[3 - nd] = 1'b0; nd++; end
         if (b_done === 1'b1 && nd < 4) begin db[3 - nd] = 1'b1; nd++; end
         if (ng == 4) break;
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0;
      for (int c = 0; c < 20 && nd < 4; c++) begin
         @(negedge clk);
         if (a_done === 1'b1) begin db[3 - nd] = 1'b0; nd++; end
         if (b_done === 1'b1 && nd < 4) begin db[3 - nd] = 1'b1; nd++; end
      end
      n_checks++;
      if (gb !== 4'b0101 || both != 0) begin
         n_fail++; $display("FAIL rr_grants: seq=%b both=%0d, required 0101 (A=0) and 0", gb, both);
      end
      n_checks++;
      if (db !== 4'b0101) begin
         n_fail++; $display("FAIL rr_dones: seq=%b, required 0101", db);
      end
      @(negedge clk);
      b_we = 1'b0; b_size = 2'b10; b_unsigned = 1'b0; b_addr = 32'hA8; b_req = 1'b1;
      #1 lone_gnt = b_gnt;
      n_checks++;
      if (lone_gnt !== 1'b1 || a_gnt !== 1'b0) begin
         n_fail++; $display("FAIL lone_b_gnt: b_gnt=%b a_gnt=%b, required 1/0", lone_gnt, a_gnt);
      end
      @(posedge clk); #1 b_req = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (b_done === 1'b1) begin lat = k; rd = rsp_rdata; break; end
      end
      n_checks++;
      if (lat !== 2 || rd !== ref_mem[42]) begin
         n_fail++; $display("FAIL lone_b_resp: lat=%0d rdata=%h, required 2/%h", lat, rd, ref_mem[42]);
      end
   endtask

   task automatic test_reset_merge;
      logic [31:0] rd, erd; logic er, eer, wr; int lat, elat, wc;
      logic in_merge;
      model(1, 2'b10, 0, 32'h28, 32'h11223344, erd, eer, elat);
      op(0, 1, 2'b10, 0, 32'h28, 32'h11223344, rd, er, lat, wc, wr);
      @(negedge clk);
      a_we = 1'b1; a_size = 2'b01; a_unsigned = 1'b0; a_addr = 32'h28; a_wdata = 32'hBEEF; a_req = 1'b1;
      @(posedge clk); #1 a_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      in_merge = mem_we;
      n_checks++;
      if (in_merge !== 1'b1 || mem_addr !== 32'd10) begin
         n_fail++; $display("FAIL merge_reached: mem_we=%b addr=%0d, required 1/10", in_merge, mem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({a_gnt, b_gnt, a_done, b_done, rsp_err, mem_we} !== 6'b0 || rsp_rdata !== 32'h0
          || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_in_merge: we=%b done=%b%b addr=%h wdata=%h, required all 0",
                            mem_we, a_done, b_done, mem_addr, mem_wdata);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (mem[10] !== 32'h11223344 || a_done !== 1'b0) begin
         n_fail++; $display("FAIL merge_abandoned: word=%h a_done=%b, required 11223344/0", mem[10], a_done);
      end
      rst_n = 1'b1;
      model(0, 2'b10, 0, 32'h28, 32'h0, erd, eer, elat);
      op(1, 0, 2'b10, 0, 32'h28, 32'h0, rd, er, lat, wc, wr);
      n_checks++;
      if (lat !== 2 || rd !== erd || er !== 1'b0 || wr) begin
         n_fail++; $display("FAIL post_reset_lw: lat=%0d rdata=%h err=%b wrong=%b, required 2/%h/0/0", lat, rd, er, wr, erd);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, erd, addr, wdata; logic er, eer, wr, port, we, uns;
      logic [1:0] size; int lat, elat, wc, widx, sel, bad;
      for (int i = 0; i < 80; i++) begin
         port  = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         uns   = 1'($urandom_range(0, 1));
         sel   = $urandom_range(0, 9);
         size  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         widx  = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 263) : $urandom_range(0, 15);
         addr  = (32'(widx) << 2) | 32'($urandom_range(0, 3));
         wdata = $urandom;
         model(we, size, uns, addr, wdata, erd, eer, elat);
         op(port, we, size, uns, addr, wdata, rd, er, lat, wc, wr);
         n_checks++;
         if (rd !== erd || er !== eer || lat !== elat || wc !== ((eer || !we) ? 0 : 1) || wr) begin
            n_fail++;
            $display("FAIL rand_%0d: port=%0d we=%b size=%0d addr=%h got rdata=%h err=%b lat=%0d we_cyc=%0d wrong=%b, required %h/%b/%0d",
                     i, port, we, size, addr, rd, er, lat, wc, wr, erd, eer, elat);
         end
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL final_memory: %0d words differ, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_subword();
      test_errors();
      test_unwritten();
      test_round_robin();
      test_reset_merge();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sequencer and arbiter in front of the word-addressed data_mem. Shares the single memory port between two requesters: port A (core load/store unit) and port B (debug/loader).
- Converts byte-addressed RV32 accesses (byte, half and word, signed or unsigned) into word accesses. Sub-word stores use read-modify-write.
- Sits between the LSU/debug logic and data_mem. Drives data_mem's write strobe, address and write data, and consumes its combinational read data.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in the attached data_mem.
- DATA_WIDTH, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held until the accepting edge.
- a_we  in  1  1 = store, 0 = load.
- a_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- a_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- a_addr  in  32  byte address.
- a_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- a_gnt  out  1  request accepted at this edge.
- a_done  out  1  one-cycle completion pulse for port A.
- b_req, b_we, b_size, b_unsigned, b_addr, b_wdata, b_gnt, b_done: port B, identical to the port A signals.
- rsp_rdata  out  32  load result; valid while a_done or b_done is high.
- rsp_err  out  1  error flag; valid while a_done or b_done is high.
- mem_we  out  1  write strobe to data_mem (cs_mem_write).
- mem_addr  out  32  word index to data_mem, equal to addr[31:2].
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  data_mem combinational read data.

Behaviour:
- Reset: async, forces state IDLE. All outputs 0; last_grant = B, so port A wins the first tie.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE: gnt is combinational. Only requesting ports compete.
  - Single requester wins.
  - Both requesting: the port other than last_grant wins (round robin).
  - On an edge with req & gnt: latch we/size/unsigned/addr/wdata and owner; update last_grant.
  - Next state is RESP with err=1 on any error, otherwise ACCESS.
- Error conditions:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:2] ≥ MEM_DEPTH.
- Errored access: no memory access occurs; rsp_rdata=0.
- ACCESS: mem_addr = latched addr[31:2].
  - Load: capture the extracted lane, extended per size/unsigned, then go to RESP.
  - Word store: mem_we=1, mem_wdata=wdata, then go to RESP.
  - Byte or half store: capture mem_rdata merged with the new lane, then go to MERGE.
- MERGE: mem_we=1, mem_wdata=merged word, mem_addr held; then go to RESP.
- Lanes (little-endian):
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half occupies [31:16] if addr[1]=1, else [15:0].
- RESP: owner's done=1 for exactly one cycle, with rsp_rdata/rsp_err valid; then go to IDLE. rsp_rdata is 0 for stores.
- Latency from the accepting edge to done high:
  - 1 cycle for an error;
  - 2 cycles for a load or word store;
  - 3 cycles for a sub-word store.
- No new grant is issued outside IDLE. Requests raised while busy wait; a waiting request wins the next IDLE cycle if it is the round-robin winner.
- mem_we is high only in ACCESS (word store) or MERGE, for exactly one cycle per store. mem_addr and mem_wdata are 0 in IDLE and RESP.
- Reset mid-operation: mem_we drops immediately (asynchronously). A pending MERGE write is abandoned, the memory word is unchanged, and no done is issued.
- Requester inputs that change after the accepting edge have no effect on the current operation.

Test Plan:
- A: sw addr 0xA8 data 0xDEADBEEF, then lw 0xA8 -> a_done 2 cycles after each grant; lw returns 0xDEADBEEF; exactly one mem_we cycle with mem_addr=42.
- After the above: sb 0xA9 data 0x55 -> 3-cycle latency, word 42 = 0xDEAD55EF. Then:
  - lb 0xAB -> 0xFFFFFFDE;
  - lbu 0xAB -> 0x000000DE;
  - lh 0xAA -> 0xFFFFDEAD;
  - sh 0xAA 0x1234 -> word 0x123455EF.
- a_req and b_req both held continuously from reset -> grants alternate A, B, A, B; no done on the wrong port; a lone B request is granted immediately.
- Error cases, each giving done 1 cycle after accept, rsp_err=1, rsp_rdata=0 and no mem_we:
  - lw 0x102;
  - lh 0x101;
  - size=11;
  - sw 0x400 (word 256).
- lw from unwritten word 55 (addr 0xDC) -> 0x00000000, rsp_err=0.
- rst_n low during MERGE of sh 0x28 data 0xBEEF -> mem_we=0 immediately, word 10 unchanged, all outputs 0. After release, B lw 0x28 is served with 2-cycle latency.
